pdm_mic_decim: RTL and testbench

PDM microphone front-end for the on-board MEMS mic and mono PWM amplifier. Generates the mic bit clock from the fast clock. Captures one or two PDM channels and decimates each with a popcount (boxcar) filter into signed PCM words with a valid strobe. Optionally loops the raw PDM stream back to the amp. Sits between the mic pins and the downstream audio/PCM processing logic.

---
 rtl/pdm_mic_decim.sv | 137 +++++++++++++
 tb/tb_pdm_mic_decim.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_mic_decim.sv
// PDM microphone front-end: bit-clock divider, mono/stereo capture, popcount decimation to signed PCM.
// PCM strobe one mclk after the frame-closing bit; no backpressure (pcm_valid is a strobe).
module pdm_mic_decim #(
  parameter int CLK_DIV = 25,
  parameter int DECIM   = 64,
  parameter int OUT_W   = 16,
  parameter int STEREO  = 0,
  parameter bit LR_SEL  = 1'b0
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             enable,
  input  logic             loop_en,
  input  logic             mic_data,
  output logic             pdm_clk,
  output logic             mic_lr_sel,
  output logic [OUT_W-1:0] pcm_l,
  output logic [OUT_W-1:0] pcm_r,
  output logic             pcm_valid,
  output logic             amp_pwm,
  output logic             amp_sd,
  output logic [15:0]      pdm_shreg
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(DECIM + 1);

  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic             pdm_clk_q, pdm_clk_d;
  logic [AW-1:0]    acc_l_q, acc_l_d;
  logic [AW-1:0]    acc_r_q, acc_r_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             frame_done_q, frame_done_d;
  logic [OUT_W-1:0] pcm_l_q, pcm_l_d;
  logic [OUT_W-1:0] pcm_r_q, pcm_r_d;
  logic             pcm_valid_q, pcm_valid_d;
  logic [15:0]      shreg_q, shreg_d;
  logic             amp_pwm_q, amp_pwm_d;
  logic             amp_sd_q, amp_sd_d;

  logic div_wrap, rise_ev, fall_ev, close_ev, frame_end;
  logic [AW-1:0] acc_l_base, acc_r_base;

  // 2*acc - DECIM, range [-DECIM, +DECIM] in two's complement
  function automatic logic [OUT_W-1:0] to_pcm(input logic [AW-1:0] acc);
    return OUT_W'({acc, 1'b0}) - OUT_W'(DECIM);
  endfunction

  always_comb begin
    div_wrap   = (div_cnt_q == DW'(CLK_DIV - 1));
    rise_ev    = enable & div_wrap & ~pdm_clk_q;
    fall_ev    = enable & div_wrap & pdm_clk_q;
    close_ev   = (STEREO != 0) ? fall_ev : rise_ev;
    frame_end  = close_ev & (bit_cnt_q == BW'(DECIM - 1));
    // the cycle after frame end restarts the accumulators, keeping any bit sampled now
    acc_l_base = frame_done_q ? '0 : acc_l_q;
    acc_r_base = frame_done_q ? '0 : acc_r_q;

    div_cnt_d    = div_wrap ? '0 : div_cnt_q + DW'(1);
    pdm_clk_d    = pdm_clk_q ^ div_wrap;
    acc_l_d      = acc_l_base + AW'(rise_ev & mic_data);
    acc_r_d      = (STEREO != 0) ? acc_r_base + AW'(fall_ev & mic_data) : '0;
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = frame_end;
    pcm_l_d      = pcm_l_q;
    pcm_r_d      = pcm_r_q;
    pcm_valid_d  = frame_done_q;
    shreg_d      = rise_ev ? {shreg_q[14:0], mic_data} : shreg_q;
    amp_pwm_d    = loop_en & shreg_q[0];
    amp_sd_d     = loop_en;

    if (close_ev) begin
      bit_cnt_d = frame_end ? '0 : bit_cnt_q + BW'(1);
    end
    if (frame_done_q) begin
      pcm_l_d = to_pcm(acc_l_q);
      pcm_r_d = (STEREO != 0) ? to_pcm(acc_r_q) : '0;
    end

    // disabling abandons any partial frame and returns everything to idle
    if (!enable) begin
      div_cnt_d    = '0;
      pdm_clk_d    = 1'b0;
      acc_l_d      = '0;
      acc_r_d      = '0;
      bit_cnt_d    = '0;
      frame_done_d = 1'b0;
      pcm_l_d      = '0;
      pcm_r_d      = '0;
      pcm_valid_d  = 1'b0;
      shreg_d      = '0;
      amp_pwm_d    = 1'b0;
      amp_sd_d     = 1'b0;
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      div_cnt_q    <= '0;
      pdm_clk_q    <= 1'b0;
      acc_l_q      <= '0;
      acc_r_q      <= '0;
      bit_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      pcm_l_q      <= '0;
      pcm_r_q      <= '0;
      pcm_valid_q  <= 1'b0;
      shreg_q      <= '0;
      amp_pwm_q    <= 1'b0;
      amp_sd_q     <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      pdm_clk_q    <= pdm_clk_d;
      acc_l_q      <= acc_l_d;
      acc_r_q      <= acc_r_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_done_q <= frame_done_d;
      pcm_l_q      <= pcm_l_d;
      pcm_r_q      <= pcm_r_d;
      pcm_valid_q  <= pcm_valid_d;
      shreg_q      <= shreg_d;
      amp_pwm_q    <= amp_pwm_d;
      amp_sd_q     <= amp_sd_d;
    end
  end

  assign pdm_clk    = pdm_clk_q;
  assign mic_lr_sel = (STEREO != 0) ? 1'b0 : LR_SEL;
  assign pcm_l      = pcm_l_q;
  assign pcm_r      = pcm_r_q;
  assign pcm_valid  = pcm_valid_q;
  assign amp_pwm    = amp_pwm_q;
  assign amp_sd     = amp_sd_q;
  assign pdm_shreg  = shreg_q;

endmodule

// File: tb/tb_pdm_mic_decim.sv
// Bench for pdm_mic_decim: a mono and a stereo instance share stimulus; an event-count model predicts every output.
module tb_pdm_mic_decim;

  localparam int C = 25;
  localparam int D = 64;

  logic mclk = 1'b0;
  logic reset, enable, loop_en, mic_data;

  logic        pdm_clk_m, mic_lr_sel_m, pcm_valid_m, amp_pwm_m, amp_sd_m;
  logic [15:0] pcm_l_m, pcm_r_m, pdm_shreg_m;
  logic        pdm_clk_s, mic_lr_sel_s, pcm_valid_s, amp_pwm_s, amp_sd_s;
  logic [15:0] pcm_l_s, pcm_r_s, pdm_shreg_s;

  pdm_mic_decim #(.CLK_DIV(C), .DECIM(D), .OUT_W(16), .STEREO(0), .LR_SEL(1'b1)) u_mono (
    .mclk(mclk), .reset(reset), .enable(enable), .loop_en(loop_en), .mic_data(mic_data),
    .pdm_clk(pdm_clk_m), .mic_lr_sel(mic_lr_sel_m), .pcm_l(pcm_l_m), .pcm_r(pcm_r_m),
    .pcm_valid(pcm_valid_m), .amp_pwm(amp_pwm_m), .amp_sd(amp_sd_m), .pdm_shreg(pdm_shreg_m));

  pdm_mic_decim #(.CLK_DIV(C), .DECIM(D), .OUT_W(16), .STEREO(1), .LR_SEL(1'b1)) u_st (
    .mclk(mclk), .reset(reset), .enable(enable), .loop_en(loop_en), .mic_data(mic_data),
    .pdm_clk(pdm_clk_s), .mic_lr_sel(mic_lr_sel_s), .pcm_l(pcm_l_s), .pcm_r(pcm_r_s),
    .pcm_valid(pcm_valid_s), .amp_pwm(amp_pwm_s), .amp_sd(amp_sd_s), .pdm_shreg(pdm_shreg_s));

  always #5 mclk = ~mclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int kind = 0;
  int strobes_m = 0, strobes_s = 0;
  int first_m = 0, last_m = 0, first_s = 0;

  // model: t counts enabled edges; events and frame sums derived arithmetically
  int t;
  int nL[2], sL[2], nR[2], sR[2], fl[2], fr[2];
  bit pend[2], e_valid[2];
  logic [15:0] e_l[2], e_r[2];
  logic [15:0] e_shreg;
  bit e_pwm, e_sd;
  int loop_pat[4] = '{1, 1, 0, 1};

  typedef struct {
    int kind;
    int exp_ml;
    int exp_sl;
    int exp_sr;
    bit tab;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic gen_bit();
    int ph;
    ph = t % (2 * C);
    case (kind)
      0: return 1'b1;
      1: return 1'b0;
      2: return ((t / (2 * C)) % 2) == 0;
      3: return ph < C;
      5: return loop_pat[(t / (2 * C)) % 4] != 0;
      default: return 1'($urandom % 2);
    endcase
  endfunction

  task automatic model_update();
    int ph;
    bit rise, fall;
    if (reset || !enable) begin
      t = 0;
      for (int i = 0; i < 2; i++) begin
        nL[i] = 0; sL[i] = 0; nR[i] = 0; sR[i] = 0;
        pend[i] = 0; e_valid[i] = 0; e_l[i] = '0; e_r[i] = '0;
      end
      e_shreg = '0; e_pwm = 0; e_sd = 0;
    end else begin
      ph = t % (2 * C);
      rise = (ph == C - 1);
      fall = (ph == 2 * C - 1);
      for (int i = 0; i < 2; i++) begin
        e_valid[i] = pend[i];
        if (pend[i]) begin
          e_l[i] = 16'(2 * fl[i] - D);
          e_r[i] = (i == 1) ? 16'(2 * fr[i] - D) : 16'd0;
          pend[i] = 0;
        end
        if (rise) begin sL[i] += int'(mic_data); nL[i]++; end
        if (fall && i == 1) begin sR[i] += int'(mic_data); nR[i]++; end
        if ((i == 0 && rise && nL[i] == D) || (i == 1 && fall && nR[i] == D)) begin
          fl[i] = sL[i]; fr[i] = sR[i];
          sL[i] = 0; nL[i] = 0; sR[i] = 0; nR[i] = 0;
          pend[i] = 1;
        end
      end
      e_pwm = loop_en & e_shreg[0];
      e_sd = loop_en;
      if (rise) e_shreg = {e_shreg[14:0], mic_data};
      t++;
    end
  endtask

  task automatic compare_all();
    logic [52:0] act, exp;
    logic e_clk;
    e_clk = ((t / C) % 2) != 0;
    act = {pdm_clk_m, pcm_valid_m, amp_pwm_m, amp_sd_m, mic_lr_sel_m, pdm_shreg_m, pcm_l_m, pcm_r_m};
    exp = {e_clk, e_valid[0], e_pwm, e_sd, 1'b1, e_shreg, e_l[0], e_r[0]};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL cycle_mono @%0d: got %h expected %h", cyc, act, exp);
    end
    act = {pdm_clk_s, pcm_valid_s, amp_pwm_s, amp_sd_s, mic_lr_sel_s, pdm_shreg_s, pcm_l_s, pcm_r_s};
    exp = {e_clk, e_valid[1], e_pwm, e_sd, 1'b0, e_shreg, e_l[1], e_r[1]};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL cycle_stereo @%0d: got %h expected %h", cyc, act, exp);
    end
    if (pcm_valid_m) begin
      strobes_m++;
      if (strobes_m == 1) first_m = cyc;
      last_m = cyc;
    end
    if (pcm_valid_s) begin
      strobes_s++;
      if (strobes_s == 1) first_s = cyc;
    end
  endtask

  task automatic step();
    @(negedge mclk);
    mic_data = gen_bit();
    @(posedge mclk);
    model_update();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    loop_en = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int base, gap, n;
    reset = 1'b1; enable = 1'b0; loop_en = 1'b0; mic_data = 1'b0;
    vecs[0] = '{0, 64, 64, 64, 1'b1};
    vecs[1] = '{1, -64, -64, -64, 1'b1};
    vecs[2] = '{2, 0, 0, 0, 1'b1};
    vecs[3] = '{3, 64, 64, -64, 1'b1};
    vecs[4] = '{4, 0, 0, 0, 1'b0};

    do_reset();
    chk("reset_pdm_clk", int'(pdm_clk_m), 0);
    chk("reset_lr_sel_mono", int'(mic_lr_sel_m), 1);
    chk("reset_lr_sel_stereo", int'(mic_lr_sel_s), 0);
    chk("reset_pcm_l", int'(pcm_l_m), 0);

    foreach (vecs[v]) begin
      do_reset();
      kind = vecs[v].kind;
      loop_en = (v % 2) == 1;
      enable = 1'b1;
      strobes_m = 0; strobes_s = 0; gap = 0;
      base = cyc;
      n = 0;
      while ((strobes_m < 2 || strobes_s < 2) && n < 7000) begin
        step();
        n++;
        if (strobes_m == 1 && pcm_valid_m) gap = cyc;
      end
      chk("frame_timeout", int'(strobes_m >= 2 && strobes_s >= 2), 1);
      chk("mono_first_strobe", first_m - base, 3176);
      chk("mono_strobe_gap", last_m - gap, 3200);
      chk("stereo_first_strobe", first_s - base, 3201);
      if (vecs[v].tab) begin
        chk("tab_mono_l", int'($signed(pcm_l_m)), vecs[v].exp_ml);
        chk("tab_mono_r", int'($signed(pcm_r_m)), 0);
        chk("tab_stereo_l", int'($signed(pcm_l_s)), vecs[v].exp_sl);
        chk("tab_stereo_r", int'($signed(pcm_r_s)), vecs[v].exp_sr);
      end
      step();
      chk("strobe_one_cycle", int'(pcm_valid_m), 0);
    end

    // loopback: left bits 1,1,0,1 appear on amp_pwm one cycle after each rise
    do_reset();
    kind = 5; loop_en = 1'b1; enable = 1'b1;
    n = 0;
    while (nL[0] < 3 && n < 500) begin step(); n++; end
    chk("loop_pwm_before", int'(amp_pwm_m), 1);
    step();
    chk("loop_pwm_after", int'(amp_pwm_m), 0);
    while (nL[0] < 4 && n < 500) begin step(); n++; end
    step();
    chk("loop_shreg", int'(pdm_shreg_m[3:0]), 4'b1101);
    chk("loop_amp_sd", int'(amp_sd_m), 1);
    chk("loop_amp_pwm", int'(amp_pwm_m), 1);
    loop_en = 1'b0;
    step();
    chk("noloop_amp_pwm", int'(amp_pwm_m), 0);
    chk("noloop_amp_sd", int'(amp_sd_m), 0);

    // enable dropped after 30 bits of ones, then a fresh frame of zeros
    kind = 0;
    n = 0;
    while (nL[0] < 30 && n < 2000) begin step(); n++; end
    enable = 1'b0;
    step();
    chk("drop_shreg", int'(pdm_shreg_m), 0);
    chk("drop_pdm_clk", int'(pdm_clk_m), 0);
    repeat (3) step();
    strobes_m = 0;
    kind = 1; enable = 1'b1;
    base = cyc;
    n = 0;
    while (strobes_m == 0 && n < 4000) begin step(); n++; end
    chk("drop_first_strobe", first_m - base, 3176);
    chk("drop_fresh_value", int'($signed(pcm_l_m)), -64);

    // reset mid-frame
    kind = 4; loop_en = 1'b1;
    repeat (1000) step();
    reset = 1'b1;
    step();
    chk("rst_pdm_clk", int'(pdm_clk_m), 0);
    chk("rst_pcm_l", int'(pcm_l_m), 0);
    chk("rst_shreg", int'(pdm_shreg_m), 0);
    chk("rst_amp_sd", int'(amp_sd_m), 0);
    reset = 1'b0;
    n = 0;
    while (pdm_clk_m == 1'b0 && n < 100) begin step(); n++; end
    chk("rst_first_rise", n, C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
